// File: rtl/imem_loader_if.sv
// Word stream into the loader and the byte-wide write port it drives.
interface imem_loader_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport master (output in_data, in_valid, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input in_data, in_valid, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Splits 32-bit words into four big-endian byte writes for the instruction memory.
// Optional running checksum of accepted words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int MEM_BYTES = 256,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [CNT_W-1:0]  word_count,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_written,
  output logic [31:0]       checksum
);
  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, BYTE, DONE} state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    addr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] words_written_reg;
  logic [31:0]      word_reg;
  logic [1:0]       beat_reg;
  logic [AW-1:0]    mem_addr_reg;
  logic [7:0]       mem_wdata_reg;
  logic             handshake;
  logic             last_word;

  assign handshake = (state_reg == WAIT) && bus.in_valid;
  assign last_word = (words_written_reg + CNT_W'(1)) == count_reg;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] b);
    case (b)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (word_count == '0) ? DONE : WAIT;
      end
      WAIT: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = BYTE;
      end
      BYTE: begin
        bus.mem_we = 1'b1;
        if (beat_reg == 2'd3) state_next = last_word ? DONE : WAIT;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The byte/address for the next beat is staged one cycle ahead so the
  // write port is driven straight from registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg          <= '0;
      count_reg         <= '0;
      words_written_reg <= '0;
      word_reg          <= '0;
      beat_reg          <= '0;
      mem_addr_reg      <= '0;
      mem_wdata_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          addr_reg          <= {base_addr[AW-1:2], 2'b00};
          count_reg         <= word_count;
          words_written_reg <= '0;
        end
        WAIT: if (bus.in_valid) begin
          word_reg      <= bus.in_data;
          beat_reg      <= 2'd0;
          mem_addr_reg  <= addr_reg;
          mem_wdata_reg <= bus.in_data[31:24];
        end
        BYTE: begin
          beat_reg <= beat_reg + 2'd1;
          if (beat_reg == 2'd3) begin
            words_written_reg <= words_written_reg + CNT_W'(1);
            addr_reg          <= addr_reg + AW'(4);
          end else begin
            mem_addr_reg  <= mem_addr_reg + AW'(1);
            mem_wdata_reg <= pick_byte(word_reg, beat_reg + 2'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = {{(32-AW){1'b0}}, mem_addr_reg};
  assign bus.mem_wdata = mem_wdata_reg;
  assign words_written = words_written_reg;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             checksum_reg <= '0;
    else if (state_reg == IDLE && start) checksum_reg <= '0;
    else if (handshake)                  checksum_reg <= checksum_reg + bus.in_data;
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Randomised and directed bench for imem_loader with a queue-based write scoreboard.
module tb_imem_loader;
  localparam int MEM_BYTES = 256;
  localparam int CNT_W     = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             busy, done;
  logic [CNT_W-1:0] words_written;
  logic [31:0]      checksum;

  imem_loader_if bus();

  imem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .bus(bus), .busy(busy), .done(done),
    .words_written(words_written), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int cmp = 0;
  int errs = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t              wq[$];
  bit               m_loading, m_done_pend, exp_we, exp_ready, was_loading;
  int               m_left, m_addr;
  logic [CNT_W-1:0] m_ww;
  logic [31:0]      m_cs, m_last_addr;
  logic [7:0]       m_last_data;
  int               log_a[$], log_d[$], log_cyc[$];
  int               done_cyc, start_cyc;

  always @(negedge clk) begin
    if (rst) begin
      wq.delete();
      m_loading = 0; m_done_pend = 0; m_left = 0; m_addr = 0;
      m_ww = '0; m_cs = '0; m_last_addr = '0; m_last_data = '0;
    end else begin
      exp_we    = wq.size() > 0;
      exp_ready = m_loading && !m_done_pend && wq.size() == 0 && m_left > 0;
      check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      check("mem_we", 32'(bus.mem_we), 32'(exp_we));
      check("busy", 32'(busy), 32'(m_loading));
      check("done", 32'(done), 32'(m_done_pend));
      check("words_written", 32'(words_written), 32'(m_ww));
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("checksum", checksum, m_cs);
`else
      check("checksum", checksum, 32'h0);
`endif
      if (exp_we) begin
        m_last_addr = wq[0].a;
        m_last_data = wq[0].d;
      end
      check("mem_addr", bus.mem_addr, m_last_addr);
      check("mem_wdata", 32'(bus.mem_wdata), 32'(m_last_data));
      if (bus.mem_we) begin
        log_a.push_back(int'(bus.mem_addr));
        log_d.push_back(int'(bus.mem_wdata));
        log_cyc.push_back(cyc);
      end
      if (done) done_cyc = cyc;

      was_loading = m_loading;
      if (m_done_pend) begin
        m_done_pend = 0;
        m_loading   = 0;
      end else if (exp_we) begin
        void'(wq.pop_front());
        if (wq.size() == 0) begin
          m_ww++;
          if (m_left == 0) m_done_pend = 1;
        end
      end
      if (exp_ready && bus.in_valid) begin
        for (int k = 0; k < 4; k++)
          wq.push_back('{a: 32'((m_addr + k) % MEM_BYTES), d: bus.in_data[31-8*k -: 8]});
        m_addr = (m_addr + 4) % MEM_BYTES;
        m_cs   = m_cs + bus.in_data;
        m_left--;
      end
      if (!was_loading && start) begin
        m_loading = 1;
        m_ww      = '0;
        m_cs      = '0;
        m_addr    = int'(base_addr % MEM_BYTES) & ~3;
        m_left    = int'(word_count);
        start_cyc = cyc;
        if (word_count == '0) m_done_pend = 1;
      end
    end
  end

  // ---------------- driver ----------------
  logic [31:0] wbuf[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    log_a.delete(); log_d.delete(); log_cyc.delete();
    done_cyc = -1;
  endtask

  task automatic feed_word(input logic [31:0] w);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 200) begin
        cmp++; errs++;
        $display("FAIL ready_wait: in_ready=0 for %0d cycles, required 1", t);
        break;
      end
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
  endtask

  task automatic load(input logic [31:0] base, input int cnt, input int gmin, input int gmax, input bit poke);
    int t;
    tick();
    start = 1'b1; base_addr = base; word_count = CNT_W'(cnt);
    tick();
    start = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(gmax, gmin)) tick();
      feed_word(wbuf[i]);
      if (poke) begin
        start = 1'b1; base_addr = $urandom; word_count = CNT_W'($urandom);
        tick();
        start = 1'b0;
      end
    end
    t = 0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      t++;
      if (t > 100) begin
        cmp++; errs++;
        $display("FAIL done_wait: done=0 for %0d cycles, required 1", t);
        break;
      end
    end
    tick();
  endtask

  task automatic check_log(input string name, input int idx, input int a, input int d);
    if (idx < log_a.size()) begin
      check({name, "_addr"}, 32'(log_a[idx]), 32'(a));
      check({name, "_data"}, 32'(log_d[idx]), 32'(d));
    end else begin
      cmp++; errs++;
      $display("FAIL %s: write %0d missing, required (%0d,%h)", name, idx, a, d);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    tick();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // single word
    clear_log();
    wbuf = '{32'hAC0A000A};
    load(32'h0, 1, 0, 0, 0);
    check_log("t1_w0", 0, 0, 'hAC);
    check_log("t1_w1", 1, 1, 'h0A);
    check_log("t1_w2", 2, 2, 'h00);
    check_log("t1_w3", 3, 3, 'h0A);
    check("t1_consec", 32'(log_cyc[3] - log_cyc[0]), 32'd3);
    check("t1_done_lat", 32'(done_cyc - log_cyc[3]), 32'd1);
    check("t1_words", 32'(words_written), 32'd1);

    // three words back-to-back, start poked during BYTE
    clear_log();
    wbuf = '{32'h014B4822, 32'h014B6820, 32'h214E0064};
    load(32'd8, 3, 0, 0, 1);
    check("t2_nwrites", 32'(log_a.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      check_log("t2", i, 8 + i, int'(wbuf[i/4] >> (24 - 8*(i%4))) & 'hFF);
    check("t2_span", 32'(done_cyc - log_cyc[0]), 32'd14);
    check("t2_words", 32'(words_written), 32'd3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t2_checksum", checksum, 32'h23E4B0A6);
`else
    check("t2_checksum", checksum, 32'h0);
`endif

    // stall 10 cycles between words
    wbuf = '{32'hDEADBEEF, 32'h01234567};
    load(32'd16, 2, 10, 10, 0);

    // zero count
    clear_log();
    load(32'd40, 0, 0, 0, 0);
    check("t4_nwrites", 32'(log_a.size()), 32'd0);
    check("t4_done_lat", 32'(done_cyc - start_cyc), 32'd1);

    // wrap
    clear_log();
    wbuf = '{32'h11223344, 32'h55667788};
    load(32'd252, 2, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      check_log("t5", i, (252 + i) % 256, 'h11 * (i + 1));

    // reset during beat 2
    tick();
    start = 1'b1; base_addr = 32'h40; word_count = 8'd3;
    tick();
    start = 1'b0;
    feed_word(32'hCAFEF00D);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("mr_mem_we", 32'(bus.mem_we), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_mem_addr", bus.mem_addr, 32'h0);
    check("mr_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    check("mr_words", 32'(words_written), 32'h0);
    check("mr_checksum", checksum, 32'h0);
    tick(); tick();
    rst = 1'b0;
    clear_log();
    wbuf = '{32'h0BADC0DE};
    load(32'h41, 1, 0, 0, 0);
    check_log("t6_w0", 0, 'h40, 'h0B);
    check_log("t6_w3", 3, 'h43, 'hDE);

    // randomised loads
    for (int n = 0; n < 25; n++) begin
      int cnt;
      cnt = $urandom_range(5, 0);
      wbuf.delete();
      for (int i = 0; i < cnt; i++) wbuf.push_back($urandom);
      load($urandom, cnt, 0, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
      repeat ($urandom_range(2, 0)) tick();
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
